// File: rtl/pkt_h.sv
// Shared header types for the flow-record path.
// Records keep the Ringslot field order: {valid, NoF, MatchFail, key}.
package pkt_h;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOOKUP  = 2'd1,
        EV_WAIT = 2'd2,
        FLUSH   = 2'd3
    } fr_state_t;

endpackage

// File: rtl/flow_key_match.sv
// DEPTH-way key comparator with a lowest-index-wins priority encoder.
// This block is purely combinational.
module flow_key_match #(
    parameter int KEY_W = 32,
    parameter int DEPTH = 16,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic [KEY_W-1:0]            key,
    input  logic [DEPTH-1:0][KEY_W-1:0] slotKeys,
    input  logic [DEPTH-1:0]            slotValid,
    output logic                        hit,
    output logic [IDX_W-1:0]            hitIdx
);

    logic [DEPTH-1:0] match;

    for (genvar i = 0; i < DEPTH; i++) begin : gMatch
        assign match[i] = slotValid[i] && (slotKeys[i] == key);
    end

    // Walk downward so the lowest matching index is the one that remains.
    always_comb begin
        hit    = |match;
        hitIdx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (match[i]) hitIdx = IDX_W'(i);
        end
    end

endmodule

// File: rtl/flow_ring_cache.sv
// Flow-record ring cache. A hit bumps the matching record's packet count.
// A miss inserts at the ring head and evicts the displaced record; a flush drains every record.
module flow_ring_cache
    import pkt_h::*;
#(
    parameter int KEY_W = 32,
    parameter int DEPTH = 16,
    parameter int NOF_W = 16,
    parameter int MF_W  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [KEY_W-1:0]           in_key,
    input  logic                       flush_req,
    output logic                       flush_done,
    output logic                       ev_valid,
    input  logic                       ev_ready,
    output logic [KEY_W-1:0]           ev_key,
    output logic [NOF_W-1:0]           ev_nof,
    output logic [MF_W-1:0]            ev_mf,
    output logic                       hit_pulse,
    output logic                       miss_pulse,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic             valid;
        logic [NOF_W-1:0] nof;
        logic [MF_W-1:0]  mf;
        logic [KEY_W-1:0] key;
    } rec_t;

    fr_state_t state, stateNext;

    rec_t [DEPTH-1:0]            slotQ;
    logic [DEPTH-1:0][KEY_W-1:0] slotKeys;
    logic [DEPTH-1:0]            slotValid;
    logic [IDX_W-1:0]            head, flushIdx, hitIdx;
    logic [KEY_W-1:0]            keyQ, evKey;
    logic [NOF_W-1:0]            evNof;
    logic [MF_W-1:0]             evMf;
    logic                        evValid, flushDone, hit;
    logic                        flushStep, flushLast;

    function automatic logic [NOF_W-1:0] incNof(input logic [NOF_W-1:0] n);
        return (&n) ? n : n + NOF_W'(1);
    endfunction

    function automatic logic [MF_W-1:0] incMf(input logic [MF_W-1:0] m);
        return (&m) ? m : m + MF_W'(1);
    endfunction

    for (genvar i = 0; i < DEPTH; i++) begin : gSlot
        assign slotKeys[i]  = slotQ[i].key;
        assign slotValid[i] = slotQ[i].valid;
    end

    flow_key_match #(.KEY_W(KEY_W), .DEPTH(DEPTH)) uMatch (
        .key      (keyQ),
        .slotKeys (slotKeys),
        .slotValid(slotValid),
        .hit      (hit),
        .hitIdx   (hitIdx)
    );

    // A flush slot is finished when its record is handed off, or right away if the slot is empty.
    assign flushStep = evValid ? ev_ready : !slotQ[flushIdx].valid;
    assign flushLast = flushStep && (flushIdx == IDX_W'(DEPTH - 1));

    assign in_ready   = rst_n && (state == IDLE) && !flush_req;
    assign hit_pulse  = (state == LOOKUP) && hit;
    assign miss_pulse = (state == LOOKUP) && !hit;
    assign ev_valid   = evValid;
    assign ev_key     = evKey;
    assign ev_nof     = evNof;
    assign ev_mf      = evMf;
    assign flush_done = flushDone;

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < DEPTH; i++) occupancy += OCC_W'(slotQ[i].valid);
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (flush_req) stateNext = FLUSH;
                     else if (in_valid) stateNext = LOOKUP;
            LOOKUP:  stateNext = (!hit && slotQ[head].valid) ? EV_WAIT : IDLE;
            EV_WAIT: if (ev_ready) stateNext = IDLE;
            FLUSH:   if (flushLast) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= stateNext;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slotQ     <= '0;
            head      <= '0;
            flushIdx  <= '0;
            keyQ      <= '0;
            evKey     <= '0;
            evNof     <= '0;
            evMf      <= '0;
            evValid   <= 1'b0;
            flushDone <= 1'b0;
        end else begin
            flushDone <= 1'b0;
            case (state)
                IDLE: begin
                    if (flush_req) flushIdx <= '0;
                    else if (in_valid) keyQ <= in_key;
                end
                LOOKUP: begin
                    for (int i = 0; i < DEPTH; i++) begin
                        if (slotQ[i].valid) begin
                            if (hit && hitIdx == IDX_W'(i)) begin
                                slotQ[i].nof <= incNof(slotQ[i].nof);
                                slotQ[i].mf  <= '0;
                            end else begin
                                slotQ[i].mf <= incMf(slotQ[i].mf);
                            end
                        end
                    end
                    if (!hit) begin
                        // The insert overrides the aging write to the head slot.
                        slotQ[head] <= '{valid: 1'b1, nof: NOF_W'(1), mf: '0, key: keyQ};
                        head        <= head + IDX_W'(1);
                        if (slotQ[head].valid) begin
                            evKey   <= slotQ[head].key;
                            evNof   <= slotQ[head].nof;
                            evMf    <= incMf(slotQ[head].mf);
                            evValid <= 1'b1;
                        end
                    end
                end
                EV_WAIT: if (ev_ready) evValid <= 1'b0;
                FLUSH: begin
                    if (evValid) begin
                        if (ev_ready) begin
                            evValid         <= 1'b0;
                            slotQ[flushIdx] <= '0;
                        end
                    end else if (slotQ[flushIdx].valid) begin
                        evKey   <= slotQ[flushIdx].key;
                        evNof   <= slotQ[flushIdx].nof;
                        evMf    <= slotQ[flushIdx].mf;
                        evValid <= 1'b1;
                    end
                    if (flushStep) begin
                        if (flushLast) begin
                            flushIdx  <= '0;
                            head      <= '0;
                            flushDone <= 1'b1;
                        end else begin
                            flushIdx <= flushIdx + IDX_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
